mobius_serial_inv: RTL



---
 rtl/mobius_serial_inv.sv | 119 +++++++++++
 1 files changed

// File: rtl/mobius_serial_inv.sv
// Serial-in, parallel-out Mobius (ANF <-> truth table) engine over GF(2).
// Loads N bits one per clock, then applies one butterfly stage per clock.
module mobius_serial_inv #(
   parameter int unsigned N      = 64,
   parameter int unsigned log2_N = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_bit,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [0:N-1] out_data,
   output logic         busy
);

   localparam int unsigned LW = log2_N;
   localparam int unsigned SW = (log2_N > 1) ? $clog2(log2_N) : 1;

   typedef enum logic [1:0] {
      ST_LOAD    = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_DONE    = 2'd2
   } state_e;

   state_e         state_q, state_d;
   logic [0:N-1]   vec_q, vec_d;
   logic [LW-1:0]  load_cnt_q, load_cnt_d;
   logic [SW-1:0]  stage_cnt_q, stage_cnt_d;
   logic           in_ready_q, in_ready_d;
   logic           out_valid_q, out_valid_d;
   logic           busy_q, busy_d;
   logic [0:N-1]   stage_vec;

   // One butterfly stage: the upper element of each pair absorbs the lower.
   // The upper partner of index i is exactly the one with the stage's half bit set.
   always_comb begin
      stage_vec = vec_q;
      for (int s = 0; s < int'(log2_N); s++) begin
         if (stage_cnt_q == SW'(s)) begin
            for (int i = 0; i < int'(N); i++) begin
               if ((i & int'(N >> (s + 1))) != 0) begin
                  stage_vec[i] = vec_q[i] ^ vec_q[i ^ int'(N >> (s + 1))];
               end
            end
         end
      end
   end

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d     = state_q;
      vec_d       = vec_q;
      load_cnt_d  = load_cnt_q;
      stage_cnt_d = stage_cnt_q;
      case (state_q)
         ST_LOAD: begin
            if (in_valid && in_ready_q) begin
               vec_d[load_cnt_q] = in_bit;
               if (load_cnt_q == LW'(N - 1)) begin
                  load_cnt_d = '0;
                  state_d    = ST_COMPUTE;
               end else begin
                  load_cnt_d = load_cnt_q + LW'(1);
               end
            end
         end
         ST_COMPUTE: begin
            vec_d = stage_vec;
            if (stage_cnt_q == SW'(log2_N - 1)) begin
               stage_cnt_d = '0;
               state_d     = ST_DONE;
            end else begin
               stage_cnt_d = stage_cnt_q + SW'(1);
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_LOAD;
            end
         end
         default: begin
            state_d     = ST_LOAD;
            load_cnt_d  = '0;
            stage_cnt_d = '0;
         end
      endcase
      in_ready_d  = (state_d == ST_LOAD);
      out_valid_d = (state_d == ST_DONE);
      busy_d      = (state_d == ST_COMPUTE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_LOAD;
         vec_q       <= '0;
         load_cnt_q  <= '0;
         stage_cnt_q <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         vec_q       <= vec_d;
         load_cnt_q  <= load_cnt_d;
         stage_cnt_q <= stage_cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign out_data  = vec_q;

endmodule
